// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared definitions for the hazard / flush controller.
//   state_e  : controller FSM states (RUN, FLUSH)
//   RegZero  : hard-wired zero register, never a hazard source
//   FcntW    : width of the remaining-flush down-counter
//   CntW     : width of the statistics counters
package hazard_flush_ctrl_pkg;

  localparam int unsigned FcntW = 2;
  localparam int unsigned CntW  = 16;
  localparam int unsigned RegW  = 3;

  localparam logic [RegW-1:0] RegZero = '0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter16.sv
// Saturating statistics counter.
//   clk_i  : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   inc_i  : increment by one at the edge (holds at all-ones)
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_o  : current count
module sat_counter16
  import hazard_flush_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard and control-flow flush controller.
// Detects load-use hazards between ID/EX and IF/ID, inserts stall bubbles,
// and flushes IF/ID (and ID/EX on a taken branch) for a programmable number
// of cycles after a redirect. Keeps saturating stall / redirect statistics.
//   clk_i, rst_n                 : clock, async active-low reset
//   IDEX_MEM_read, IDEX_RT_reg   : load in ID/EX and its destination
//   IFID_RS_reg/RT_reg/use_rs/rt : IF/ID source operands and their use flags
//   Branch_taken                 : branch resolved taken in EX
//   Jump_ID                      : jump decoded in ID
//   stat_clr                     : synchronous statistics clear
//   PC_write, IF_ID_write        : pipeline write enables
//   Data_ID_EX_Flush             : load-use bubble into ID/EX
//   Branch_IF_ID_Flush/ID_EX     : redirect flushes
//   stall_cnt_o, flush_cnt_o     : saturating statistics
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned BR_FLUSH_CYC  = 1,
  parameter int unsigned JMP_FLUSH_CYC = 1
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            IDEX_MEM_read,
  input  logic [RegW-1:0] IDEX_RT_reg,
  input  logic [RegW-1:0] IFID_RS_reg,
  input  logic [RegW-1:0] IFID_RT_reg,
  input  logic            IFID_use_rs,
  input  logic            IFID_use_rt,
  input  logic            Branch_taken,
  input  logic            Jump_ID,
  input  logic            stat_clr,
  output logic            PC_write,
  output logic            IF_ID_write,
  output logic            Data_ID_EX_Flush,
  output logic            Branch_IF_ID_Flush,
  output logic            Branch_ID_EX_Flush,
  output logic [CntW-1:0] stall_cnt_o,
  output logic [CntW-1:0] flush_cnt_o
);

  // Remaining IF/ID flush cycles after the redirect cycle itself.
  localparam logic [FcntW-1:0] BrReload  = FcntW'(BR_FLUSH_CYC - 1);
  localparam logic [FcntW-1:0] JmpReload = FcntW'(JMP_FLUSH_CYC - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [FcntW-1:0] r_fcnt;
  logic [FcntW-1:0] w_fcnt_d;

  logic w_hazard;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_data_flush;
  logic w_br_ifid_flush;
  logic w_br_idex_flush;
  logic w_redirect;

  assign w_hazard = IDEX_MEM_read && (IDEX_RT_reg != RegZero) &&
                    ((IFID_use_rs && (IFID_RS_reg == IDEX_RT_reg)) ||
                     (IFID_use_rt && (IFID_RT_reg == IDEX_RT_reg)));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_fcnt  <= w_fcnt_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_fcnt_d        = r_fcnt;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_data_flush    = 1'b0;
    w_br_ifid_flush = 1'b0;
    w_br_idex_flush = 1'b0;
    w_redirect      = 1'b0;

    if (Branch_taken) begin
      // A taken branch overrides everything, including an active flush window.
      w_br_ifid_flush = 1'b1;
      w_br_idex_flush = 1'b1;
      w_redirect      = 1'b1;
      if (BR_FLUSH_CYC > 1) begin
        w_state_d = FLUSH;
        w_fcnt_d  = BrReload;
      end else begin
        w_state_d = RUN;
        w_fcnt_d  = '0;
      end
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_hazard) begin
            // Stall; a pending jump stays in IF/ID and is taken next cycle.
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_data_flush = 1'b1;
          end else if (Jump_ID) begin
            w_br_ifid_flush = 1'b1;
            w_redirect      = 1'b1;
            if (JMP_FLUSH_CYC > 1) begin
              w_state_d = FLUSH;
              w_fcnt_d  = JmpReload;
            end
          end
        end
        FLUSH: begin
          // IF/ID holds a bubble, so hazard and jump inputs are meaningless.
          w_br_ifid_flush = 1'b1;
          if (r_fcnt > FcntW'(1)) begin
            w_fcnt_d = r_fcnt - FcntW'(1);
          end else begin
            w_state_d = RUN;
            w_fcnt_d  = '0;
          end
        end
        default: begin
          w_state_d = RUN;
          w_fcnt_d  = '0;
        end
      endcase
    end
  end

  // Reset forces safe pipeline controls without waiting for a clock.
  assign PC_write           = rst_n ? w_pc_write      : 1'b1;
  assign IF_ID_write        = rst_n ? w_ifid_write    : 1'b1;
  assign Data_ID_EX_Flush   = rst_n ? w_data_flush    : 1'b0;
  assign Branch_IF_ID_Flush = rst_n ? w_br_ifid_flush : 1'b0;
  assign Branch_ID_EX_Flush = rst_n ? w_br_idex_flush : 1'b0;

  sat_counter16 u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (w_data_flush),
    .clr_i (stat_clr),
    .cnt_o (stall_cnt_o)
  );

  sat_counter16 u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (w_redirect),
    .clr_i (stat_clr),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: two instances (default flush lengths and
// BR=3/JMP=2) share one stimulus stream and are checked against a model that
// tracks "remaining IF/ID flush cycles" as a plain integer.
module tb_hazard_flush_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b1;
  logic       IDEX_MEM_read = 1'b0;
  logic [2:0] IDEX_RT_reg = '0;
  logic [2:0] IFID_RS_reg = '0;
  logic [2:0] IFID_RT_reg = '0;
  logic       IFID_use_rs = 1'b0;
  logic       IFID_use_rt = 1'b0;
  logic       Branch_taken = 1'b0;
  logic       Jump_ID = 1'b0;
  logic       stat_clr = 1'b0;

  logic        pc_w  [2];
  logic        ifid_w[2];
  logic        d_fl  [2];
  logic        bif_fl[2];
  logic        bidex_fl[2];
  logic [15:0] sc    [2];
  logic [15:0] fc    [2];

  int total = 0;
  int bad   = 0;

  // Model state per instance
  int br_len [2] = '{1, 3};
  int jmp_len[2] = '{1, 2};
  int rem    [2];
  int m_sc   [2];
  int m_fc   [2];

  always #5 clk_i = ~clk_i;

  hazard_flush_ctrl #(.BR_FLUSH_CYC(1), .JMP_FLUSH_CYC(1)) u_dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .IDEX_MEM_read(IDEX_MEM_read), .IDEX_RT_reg(IDEX_RT_reg),
    .IFID_RS_reg(IFID_RS_reg), .IFID_RT_reg(IFID_RT_reg), .IFID_use_rs(IFID_use_rs),
    .IFID_use_rt(IFID_use_rt), .Branch_taken(Branch_taken), .Jump_ID(Jump_ID),
    .stat_clr(stat_clr), .PC_write(pc_w[0]), .IF_ID_write(ifid_w[0]),
    .Data_ID_EX_Flush(d_fl[0]), .Branch_IF_ID_Flush(bif_fl[0]),
    .Branch_ID_EX_Flush(bidex_fl[0]), .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0])
  );

  hazard_flush_ctrl #(.BR_FLUSH_CYC(3), .JMP_FLUSH_CYC(2)) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .IDEX_MEM_read(IDEX_MEM_read), .IDEX_RT_reg(IDEX_RT_reg),
    .IFID_RS_reg(IFID_RS_reg), .IFID_RT_reg(IFID_RT_reg), .IFID_use_rs(IFID_use_rs),
    .IFID_use_rt(IFID_use_rt), .Branch_taken(Branch_taken), .Jump_ID(Jump_ID),
    .stat_clr(stat_clr), .PC_write(pc_w[1]), .IF_ID_write(ifid_w[1]),
    .Data_ID_EX_Flush(d_fl[1]), .Branch_IF_ID_Flush(bif_fl[1]),
    .Branch_ID_EX_Flush(bidex_fl[1]), .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hazard();
    return IDEX_MEM_read && (IDEX_RT_reg != 0) &&
           ((IFID_use_rs && IFID_RS_reg == IDEX_RT_reg) ||
            (IFID_use_rt && IFID_RT_reg == IDEX_RT_reg));
  endfunction

  // Expected pipeline controls: {pc, ifid_w, data_flush, br_ifid, br_idex}
  function automatic logic [4:0] model_out(input int k);
    if (!rst_n)          return 5'b11000;
    if (Branch_taken)    return 5'b11011;
    if (rem[k] > 0)      return 5'b11010;
    if (hazard())        return 5'b00100;
    if (Jump_ID)         return 5'b11010;
    return 5'b11000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    bit s_inc = 0;
    bit f_inc = 0;
    if (Branch_taken) begin
      f_inc = 1; rem[k] = br_len[k] - 1;
    end else if (rem[k] > 0) begin
      rem[k]--;
    end else if (hazard()) begin
      s_inc = 1;
    end else if (Jump_ID) begin
      f_inc = 1; rem[k] = jmp_len[k] - 1;
    end
    if (stat_clr) begin
      m_sc[k] = 0; m_fc[k] = 0;
    end else begin
      if (s_inc && m_sc[k] < 65535) m_sc[k]++;
      if (f_inc && m_fc[k] < 65535) m_fc[k]++;
    end
  endtask

  task automatic check_outs(input int k);
    logic [4:0] e;
    e = model_out(k);
    check_eq($sformatf("pc_write%0d", k),  32'(pc_w[k]),     32'(e[4]));
    check_eq($sformatf("ifid_write%0d", k), 32'(ifid_w[k]),  32'(e[3]));
    check_eq($sformatf("data_flush%0d", k), 32'(d_fl[k]),    32'(e[2]));
    check_eq($sformatf("br_ifid%0d", k),    32'(bif_fl[k]),  32'(e[1]));
    check_eq($sformatf("br_idex%0d", k),    32'(bidex_fl[k]), 32'(e[0]));
  endtask

  task automatic check_cnts(input int k);
    check_eq($sformatf("stall_cnt%0d", k), 32'(sc[k]), 32'(m_sc[k]));
    check_eq($sformatf("flush_cnt%0d", k), 32'(fc[k]), 32'(m_fc[k]));
  endtask

  // One clock: check controls mid-cycle, advance model at the edge, check counters.
  task automatic step();
    @(negedge clk_i);
    for (int k = 0; k < 2; k++) check_outs(k);
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    for (int k = 0; k < 2; k++) check_cnts(k);
  endtask

  task automatic idle_inputs();
    IDEX_MEM_read = 0; IDEX_RT_reg = 0; IFID_RS_reg = 0; IFID_RT_reg = 0;
    IFID_use_rs = 0; IFID_use_rt = 0; Branch_taken = 0; Jump_ID = 0; stat_clr = 0;
  endtask

  task automatic load_use(input logic [2:0] rt);
    IDEX_MEM_read = 1; IDEX_RT_reg = rt; IFID_RS_reg = rt; IFID_use_rs = 1;
    IFID_RT_reg = 3'd6; IFID_use_rt = 0;
  endtask

  initial begin
    int fc_before;
    model_reset();

    // Reset forces safe controls regardless of hazard / branch inputs.
    #1 rst_n = 0;
    load_use(3'd3); Jump_ID = 1;
    #2;
    for (int k = 0; k < 2; k++) begin
      check_outs(k);
      check_cnts(k);
    end
    Branch_taken = 1;
    #1 check_outs(1);
    @(negedge clk_i);
    idle_inputs();
    rst_n = 1;
    @(posedge clk_i); #1;

    // Register zero never stalls.
    load_use(3'd0);
    step();
    check_eq("req23_no_stall", 32'(sc[0]), 32'd0);

    // Basic load-use stall.
    load_use(3'd3);
    step();
    check_eq("req22_stall_cnt", 32'(sc[0]), 32'd1);
    idle_inputs(); step();

    // Branch wins over a simultaneous hazard.
    load_use(3'd3); Branch_taken = 1;
    step();
    check_eq("req24_flush_cnt", 32'(fc[0]), 32'd1);
    check_eq("req24_stall_cnt", 32'(sc[0]), 32'd1);
    idle_inputs();
    repeat (3) step();

    // Long branch flush, then a second branch extending the window.
    Branch_taken = 1; step(); Branch_taken = 0;
    repeat (3) step();
    Branch_taken = 1; step(); step(); Branch_taken = 0;
    repeat (4) step();

    // Jump held off by a load-use stall, taken the next cycle.
    fc_before = int'(fc[0]);
    load_use(3'd5); Jump_ID = 1;
    step();
    check_eq("req26_stall_no_flush", 32'(fc[0]), 32'(fc_before));
    IDEX_MEM_read = 0;
    step();
    check_eq("req26_jump_counted", 32'(fc[0]), 32'(fc_before + 1));
    idle_inputs(); repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      IDEX_MEM_read = ($urandom_range(0, 1) == 1);
      IDEX_RT_reg   = 3'($urandom_range(0, 3));
      IFID_RS_reg   = 3'($urandom_range(0, 3));
      IFID_RT_reg   = 3'($urandom_range(0, 3));
      IFID_use_rs   = ($urandom_range(0, 1) == 1);
      IFID_use_rt   = ($urandom_range(0, 1) == 1);
      Branch_taken  = ($urandom_range(0, 7) == 0);
      Jump_ID       = ($urandom_range(0, 3) == 0);
      stat_clr      = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();

    // Reset dropped in the middle of a flush window.
    Branch_taken = 1; step();
    load_use(3'd2); Jump_ID = 1; Branch_taken = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check_outs(k);
      check_cnts(k);
    end
    @(negedge clk_i);
    idle_inputs();
    rst_n = 1;
    @(posedge clk_i); #1;
    step();
    check_eq("req19_run_after_reset", 32'(bif_fl[1]), 32'd0);

    // Saturation of the redirect counter.
    stat_clr = 1; step(); stat_clr = 0;
    Branch_taken = 1;
    repeat (65534) step();
    check_eq("req27_preload", 32'(fc[0]), 32'hFFFE);
    repeat (3) step();
    check_eq("req27_saturate0", 32'(fc[0]), 32'hFFFF);
    check_eq("req27_saturate1", 32'(fc[1]), 32'hFFFF);
    Branch_taken = 0;

    // Clear beats increment.
    Branch_taken = 1; stat_clr = 1; step();
    check_eq("clr_priority", 32'(fc[0]), 32'd0);
    idle_inputs(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
